ts_tx_fifo: RTL and testbench

- Sits directly downstream of the TS generator.
- Buffers 128-bit training-set ordered sets pushed on ts/ts_valid and back-pressures the generator via ts_tx_fifo_full.
- Serializes each TS into 16 symbols on the lane-side symbol interface, paced to the current link rate from a 1 GHz system clock.
- The LTSSM model's transmit path terminates here.

---
 rtl/ts_tx_fifo_pkg.sv | 16 +
 rtl/ts_sym_pacer.sv | 64 ++++++
 rtl/ts_tx_fifo.sv | 147 ++++++++++++++
 tb/tb_ts_tx_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ts_tx_fifo_pkg.sv
// Shared constants and serializer state encoding for the TS transmit FIFO.
package ts_tx_fifo_pkg;
  localparam int TS_SYMS = 16;
  localparam int SYM_W = 8;
  localparam int TS_W = TS_SYMS * SYM_W;
  localparam int IDX_W = $clog2(TS_SYMS);
  localparam logic [SYM_W-1:0] SYM_COM = 8'hBC;
  localparam int GEN1_DIV_DEF = 4;
  localparam int GEN2_DIV_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } ser_state_e;
endpackage

// File: rtl/ts_sym_pacer.sv
// Symbol pacing: per-symbol down-counter plus symbol index within the TS.
module ts_sym_pacer
  import ts_tx_fifo_pkg::*;
#(
  parameter int GEN1_DIV = GEN1_DIV_DEF,
  parameter int GEN2_DIV = GEN2_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  input  logic spd_i,
  output logic strobe_o,
  output logic adv_o,
  output logic first_o,
  output logic last_o
);
  localparam int PW = $clog2((GEN1_DIV > GEN2_DIV) ? GEN1_DIV : GEN2_DIV);
  localparam logic [PW-1:0] TC1 = PW'(GEN1_DIV - 1);
  localparam logic [PW-1:0] TC2 = PW'(GEN2_DIV - 1);

  logic             spd_q, spd_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    tc;

  assign tc = spd_q ? TC2 : TC1;

  // Counter reloads to DIV-1 at the start of each symbol period; strobe on reload value, advance at zero.
  always_comb begin
    spd_d = spd_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (load_i) begin
      spd_d = spd_i;
      cnt_d = spd_i ? TC2 : TC1;
      idx_d = '0;
    end else if (run_i) begin
      if (cnt_q == '0) begin
        cnt_d = tc;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      spd_q <= spd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign strobe_o = run_i && (cnt_q == tc);
  assign adv_o    = run_i && (cnt_q == '0);
  assign first_o  = (idx_q == '0);
  assign last_o   = (idx_q == IDX_W'(TS_SYMS - 1));
endmodule

// File: rtl/ts_tx_fifo.sv
// TS transmit FIFO and symbol serializer; TS_TX_STATS_EN adds tx_ts_cnt/tx_drop_cnt counters.
module ts_tx_fifo
  import ts_tx_fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int GEN1_DIV = GEN1_DIV_DEF,
  parameter int GEN2_DIV = GEN2_DIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ts_valid,
  input  logic [TS_W-1:0] ts,
  input  logic            speed,
  output logic            ts_tx_fifo_full,
  output logic [7:0]      tx_sym,
  output logic            tx_sym_valid,
  output logic            tx_sym_k,
  output logic            tx_ts_done,
  output logic            tx_idle,
  output logic            tx_overflow
`ifdef TS_TX_STATS_EN
  ,
  output logic [15:0]     tx_ts_cnt,
  output logic [15:0]     tx_drop_cnt
`endif
);
  logic [TS_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            full_q, ovf_q;
  ser_state_e      state_q, state_d;
  logic [TS_W-1:0] shift_q, shift_d;
  logic [7:0]      sym_q, sym_d;
  logic            sym_valid_q, sym_k_q, sym_k_d, done_q, done_d, idle_q, idle_d;
  logic            push, drop, pop;
  logic            strobe, adv, first, last;

  assign push = ts_valid && !full_q;
  assign drop = ts_valid && full_q;
  assign pop  = (state_q == ST_LOAD);

  ts_sym_pacer #(.GEN1_DIV(GEN1_DIV), .GEN2_DIV(GEN2_DIV)) u_pacer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pop),
    .run_i    (state_q == ST_SEND),
    .spd_i    (speed),
    .strobe_o (strobe),
    .adv_o    (adv),
    .first_o  (first),
    .last_o   (last)
  );

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ts;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: if (count_q != '0) state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = mem_q[rd_ptr_q];
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (adv) shift_d = {8'h00, shift_q[TS_W-1:8]};
        if (adv && last) state_d = (count_q != '0) ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output stage is registered, so it lags the pacer strobe by one clock.
  always_comb begin
    sym_d   = strobe ? shift_q[7:0] : sym_q;
    sym_k_d = strobe && first && (shift_q[7:0] == SYM_COM);
    done_d  = strobe && last;
    idle_d  = (count_d == '0) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_k_q     <= 1'b0;
      done_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      full_q      <= (count_d == (AW+1)'(DEPTH));
      if (drop) ovf_q <= 1'b1;
      state_q     <= state_d;
      shift_q     <= shift_d;
      sym_q       <= sym_d;
      sym_valid_q <= strobe;
      sym_k_q     <= sym_k_d;
      done_q      <= done_d;
      idle_q      <= idle_d;
    end
  end

  assign ts_tx_fifo_full = full_q;
  assign tx_sym          = sym_q;
  assign tx_sym_valid    = sym_valid_q;
  assign tx_sym_k        = sym_k_q;
  assign tx_ts_done      = done_q;
  assign tx_idle         = idle_q;
  assign tx_overflow     = ovf_q;

`ifdef TS_TX_STATS_EN
  logic [15:0] ts_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (done_d && ts_cnt_q != 16'hFFFF)  ts_cnt_q   <= ts_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign tx_ts_cnt   = ts_cnt_q;
  assign tx_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_ts_tx_fifo.sv
// Randomized bench for ts_tx_fifo against a transaction-level schedule model; define TS_TX_STATS_EN to cover the counters.
module tb_ts_tx_fifo;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ts_valid;
  logic [127:0] ts;
  logic         speed;
  logic         ts_tx_fifo_full;
  logic [7:0]   tx_sym;
  logic         tx_sym_valid, tx_sym_k, tx_ts_done, tx_idle, tx_overflow;
`ifdef TS_TX_STATS_EN
  logic [15:0]  tx_ts_cnt, tx_drop_cnt;
`endif

  ts_tx_fifo #(.DEPTH(DEPTH), .AW(2), .GEN1_DIV(4), .GEN2_DIV(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .ts_valid        (ts_valid),
    .ts              (ts),
    .speed           (speed),
    .ts_tx_fifo_full (ts_tx_fifo_full),
    .tx_sym          (tx_sym),
    .tx_sym_valid    (tx_sym_valid),
    .tx_sym_k        (tx_sym_k),
    .tx_ts_done      (tx_ts_done),
    .tx_idle         (tx_idle),
    .tx_overflow     (tx_overflow)
`ifdef TS_TX_STATS_EN
    ,
    .tx_ts_cnt       (tx_ts_cnt),
    .tx_drop_cnt     (tx_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: accepted TS entries with their push edge, and the expected symbol schedule.
  typedef struct { logic [127:0] d; int t; } ent_t;
  typedef struct { int e; logic [7:0] sym; logic k; logic done; } sym_t;

  ent_t mq[$];
  sym_t xq[$];
  int   edge_n = 0;
  int   busy_end;
  logic [7:0] last_sym;
  logic m_ovf;
  int   m_ts_cnt, m_drop_cnt;

  function automatic void m_reset();
    mq.delete();
    xq.delete();
    busy_end   = -1000;
    last_sym   = 8'h00;
    m_ovf      = 1'b0;
    m_ts_cnt   = 0;
    m_drop_cnt = 0;
  endfunction

  // A TS is loaded at the first edge that is >=2 after its push and >=1 after the previous TS ends.
  function automatic void model_edge(input logic v, input logic [127:0] d, input logic s);
    logic acc;
    int   div;
    ent_t en;
    sym_t sy;
    acc = v && (mq.size() < DEPTH);
    if (v && !acc) begin
      m_ovf = 1'b1;
      if (m_drop_cnt < 65535) m_drop_cnt++;
    end
    if (mq.size() > 0 && mq[0].t <= edge_n - 2 && edge_n >= busy_end + 1) begin
      en  = mq.pop_front();
      div = s ? 2 : 4;
      for (int k = 0; k < 16; k++) begin
        sy.e    = edge_n + 1 + k * div;
        sy.sym  = en.d[8*k +: 8];
        sy.k    = (k == 0) && (sy.sym == 8'hBC);
        sy.done = (k == 15);
        xq.push_back(sy);
      end
      busy_end = edge_n + 16 * div;
    end
    if (acc) begin
      en.d = d;
      en.t = edge_n;
      mq.push_back(en);
    end
  endfunction

  task automatic compare_outputs();
    sym_t sy;
    if (xq.size() > 0 && xq[0].e == edge_n) begin
      sy = xq.pop_front();
      check("sym_valid", tx_sym_valid, 1'b1);
      check("sym", tx_sym, sy.sym);
      check("sym_k", tx_sym_k, sy.k);
      check("ts_done", tx_ts_done, sy.done);
      last_sym = sy.sym;
      if (sy.done && m_ts_cnt < 65535) m_ts_cnt++;
    end else begin
      check("sym_valid_idle", tx_sym_valid, 1'b0);
      check("ts_done_idle", tx_ts_done, 1'b0);
      check("sym_hold", tx_sym, last_sym);
    end
    check("full", ts_tx_fifo_full, mq.size() == DEPTH);
    check("idle", tx_idle, (mq.size() == 0) && (edge_n >= busy_end));
    check("overflow", tx_overflow, m_ovf);
`ifdef TS_TX_STATS_EN
    check("ts_cnt", tx_ts_cnt, 16'(m_ts_cnt));
    check("drop_cnt", tx_drop_cnt, 16'(m_drop_cnt));
`endif
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic v, input logic [127:0] d, input logic s);
    ts_valid = v;
    ts       = d;
    speed    = s;
    @(posedge clk);
    edge_n++;
    model_edge(v, d, s);
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic s);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, s);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ts_valid = 1'b0;
    #1;
    m_reset();
    check("rst_sym_valid", tx_sym_valid, 1'b0);
    check("rst_ts_done", tx_ts_done, 1'b0);
    check("rst_sym", tx_sym, 8'h00);
    check("rst_sym_k", tx_sym_k, 1'b0);
    check("rst_full", ts_tx_fifo_full, 1'b0);
    check("rst_idle", tx_idle, 1'b1);
    check("rst_overflow", tx_overflow, 1'b0);
`ifdef TS_TX_STATS_EN
    check("rst_ts_cnt", tx_ts_cnt, 16'h0);
    check("rst_drop_cnt", tx_drop_cnt, 16'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [127:0] rnd_ts();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 2) == 0) r[7:0] = 8'hBC;
    return r;
  endfunction

  initial begin
    logic [127:0] d;
    logic         spd;
    ts_valid = 1'b0;
    ts       = '0;
    speed    = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Gen1 single TS with COM in slot 0
    d = rnd_ts();
    d[7:0]  = 8'hBC;
    d[15:8] = 8'hF7;
    cycle(1'b1, d, 1'b0);
    idle_cycles(75, 1'b0);

    // Gen2 back-to-back
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_ts(), 1'b1);
    idle_cycles(110, 1'b1);

    // Fill and overflow while the serializer is busy
    cycle(1'b1, rnd_ts(), 1'b0);
    idle_cycles(5, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_ts(), 1'b0);
    idle_cycles(340, 1'b0);

    // Speed change mid-TS
    cycle(1'b1, rnd_ts(), 1'b0);
    idle_cycles(9, 1'b0);
    cycle(1'b1, rnd_ts(), 1'b0);
    idle_cycles(13, 1'b0);
    idle_cycles(110, 1'b1);

    // Reset mid-TS at symbol 7
    cycle(1'b1, rnd_ts(), 1'b0);
    idle_cycles(31, 1'b0);
    do_reset();
    idle_cycles(10, 1'b0);
    d = rnd_ts();
    cycle(1'b1, d, 1'b0);
    idle_cycles(75, 1'b0);

    // Randomized traffic
    spd = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) spd = ~spd;
      if ($urandom_range(0, 9) == 0) cycle(1'b1, rnd_ts(), spd);
      else                            cycle(1'b0, '0, spd);
    end
    idle_cycles(350, spd);

    check("drained_schedule", 128'(xq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
